// File: rtl/spi_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_pkg
//   Shared constants for the SPI command sequencer:
//     - FSM state encoding (plain localparams so legacy tools can decode them)
//     - err_code values reported to the host
//     - the reserved idle/abort command code
// -----------------------------------------------------------------------------
package spi_cmd_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_FIN      = 2'd3;

    // err_code values (sticky until the host writes the idle code)
    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_ILL  = 2'b01;
    localparam logic [1:0] ERR_EXEC = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

    // Command code meaning "idle" when written, "abort" while a command runs
    localparam int CMD_IDLE = 0;

endpackage

// File: rtl/spi_cmd_sequencer_cmp.sv
// -----------------------------------------------------------------------------
// sequence_comparator_diff
//   Keeps a copy of the previous command word and flags a new command when the
//   word changes to a non-idle value. Rewriting the same code is therefore not
//   a new command; the host has to go through 0 or a different code.
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset (previous word clears to 0)
//   word_i  in   current command word from the SPI shadow register
//   new_o   out  word differs from last cycle and is not the idle code
//   zero_o  out  word equals the idle code
// -----------------------------------------------------------------------------
module sequence_comparator_diff
    import spi_cmd_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] word_i,
    output logic             new_o,
    output logic             zero_o
);

    logic [width-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= word_i;
        end
    end

    assign zero_o = (word_i == width'(CMD_IDLE));
    assign new_o  = (word_i != prev_q) && !zero_o;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
//   Takes command words written by the SPI slave, validates them and hands
//   legal ones to the command executor over a level req / pulse ack handshake.
//   Supervises the executor with a timeout, aborts when the host writes the
//   idle code mid-command, and buffers one command arriving while busy.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   cmd_word   in   command word from the SPI shadow register
//   cmd_arg    in   argument, sampled together with cmd_word
//   exec_req   out  request level to the executor (registered)
//   exec_cmd   out  latched command, stable while exec_req is high
//   exec_arg   out  latched argument, stable while exec_req is high
//   exec_ack   in   executor completion pulse
//   exec_err   in   executor failure flag, valid with exec_ack
//   busy       out  sequencer not idle
//   done       out  one pulse per finished or rejected command
//   err_code   out  sticky status: ok / illegal / exec error / timeout
//   cmd_abort  out  one pulse telling the executor to drop its command
//   pend_ovf   out  sticky: a buffered command was overwritten
// -----------------------------------------------------------------------------
module spi_cmd_sequencer
    import spi_cmd_pkg::*;
#(
    parameter int CMD_W   = 8,
    parameter int ARG_W   = 16,
    parameter int MAX_CMD = 15,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] cmd_word,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic             exec_req,
    output logic [CMD_W-1:0] exec_cmd,
    output logic [ARG_W-1:0] exec_arg,
    input  logic             exec_ack,
    input  logic             exec_err,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err_code,
    output logic             cmd_abort,
    output logic             pend_ovf
);

    localparam logic [CMD_W-1:0] MAX_CMD_C = CMD_W'(MAX_CMD);
    // Last counter value before timeout: the request is held for exactly
    // TIMEOUT cycles when no ack arrives.
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    function automatic logic is_legal(input logic [CMD_W-1:0] c);
        return (c <= MAX_CMD_C);
    endfunction

    logic             new_cmd;
    logic             zero;

    logic [1:0]       state_q,    state_d;
    logic             req_q,      req_d;
    logic [CMD_W-1:0] cmd_q,      cmd_d;
    logic [ARG_W-1:0] arg_q,      arg_d;
    logic             done_q,     done_d;
    logic [1:0]       err_q,      err_d;
    logic             abort_q,    abort_d;
    logic             ovf_q,      ovf_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CMD_W-1:0] pend_cmd_q, pend_cmd_d;
    logic [ARG_W-1:0] pend_arg_q, pend_arg_d;
    logic [TO_W-1:0]  cnt_q,      cnt_d;

    sequence_comparator_diff #(.width(CMD_W)) u_cmp (
        .clk    (clk),
        .rst_n  (rst_n),
        .word_i (cmd_word),
        .new_o  (new_cmd),
        .zero_o (zero)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        done_d     = 1'b0;
        err_d      = err_q;
        abort_d    = 1'b0;
        ovf_d      = ovf_q;
        pend_vld_d = pend_vld_q;
        pend_cmd_d = pend_cmd_q;
        pend_arg_d = pend_arg_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (new_cmd) begin
                    if (is_legal(cmd_word)) begin
                        cmd_d   = cmd_word;
                        arg_d   = cmd_arg;
                        req_d   = 1'b1;
                        err_d   = ERR_OK;
                        state_d = ST_WAIT_ACK;
                    end else begin
                        // Rejected without ever reaching the executor
                        err_d  = ERR_ILL;
                        done_d = 1'b1;
                    end
                end else if (zero) begin
                    // Host acknowledge of the previous status
                    err_d = ERR_OK;
                    ovf_d = 1'b0;
                end
            end

            ST_WAIT_ACK: begin
                // Priority: ack, then timeout, then host abort
                if (exec_ack) begin
                    req_d   = 1'b0;
                    err_d   = exec_err ? ERR_EXEC : ERR_OK;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else if (cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    err_d   = ERR_TO;
                    abort_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else if (zero) begin
                    // Host abort: no done, status untouched, buffer discarded
                    req_d      = 1'b0;
                    abort_d    = 1'b1;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_FIN: begin
                cnt_d   = '0;
                state_d = pend_vld_q ? ST_ISSUE : ST_IDLE;
            end

            ST_ISSUE: begin
                cnt_d      = '0;
                pend_vld_d = 1'b0;
                if (is_legal(pend_cmd_q)) begin
                    cmd_d   = pend_cmd_q;
                    arg_d   = pend_arg_q;
                    req_d   = 1'b1;
                    err_d   = ERR_OK;
                    state_d = ST_WAIT_ACK;
                end else begin
                    err_d   = ERR_ILL;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One-deep buffer for commands arriving while busy. In ISSUE the slot
        // is being consumed this cycle, so refilling it is not an overwrite.
        if (new_cmd && (state_q != ST_IDLE)) begin
            pend_cmd_d = cmd_word;
            pend_arg_d = cmd_arg;
            pend_vld_d = 1'b1;
            if (pend_vld_q && (state_q != ST_ISSUE)) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            cmd_q      <= '0;
            arg_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= ERR_OK;
            abort_q    <= 1'b0;
            ovf_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_cmd_q <= '0;
            pend_arg_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            done_q     <= done_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            ovf_q      <= ovf_d;
            pend_vld_q <= pend_vld_d;
            pend_cmd_q <= pend_cmd_d;
            pend_arg_q <= pend_arg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign exec_req  = req_q;
    assign exec_cmd  = cmd_q;
    assign exec_arg  = arg_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err_code  = err_q;
    assign cmd_abort = abort_q;
    assign pend_ovf  = ovf_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_sequencer
//   Directed scenarios followed by randomized command transactions. Expected
//   values come from transaction-level rules: legality by code range, request
//   one cycle after a write, timeout after TIMEOUT request cycles, status codes
//   from the ack/err outcome, buffered command issued two cycles after done.
// -----------------------------------------------------------------------------
module tb_spi_cmd_sequencer;

    localparam int CMD_W   = 8;
    localparam int ARG_W   = 16;
    localparam int MAX_CMD = 15;
    localparam int TIMEOUT = 8;
    localparam int TO_W    = 4;

    logic             clk;
    logic             rst_n;
    logic [CMD_W-1:0] cmd_word;
    logic [ARG_W-1:0] cmd_arg;
    logic             exec_req;
    logic [CMD_W-1:0] exec_cmd;
    logic [ARG_W-1:0] exec_arg;
    logic             exec_ack;
    logic             exec_err;
    logic             busy;
    logic             done;
    logic [1:0]       err_code;
    logic             cmd_abort;
    logic             pend_ovf;

    int tests = 0;
    int fails = 0;
    logic saw7 = 1'b0;

    spi_cmd_sequencer #(
        .CMD_W(CMD_W), .ARG_W(ARG_W), .MAX_CMD(MAX_CMD),
        .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_word(cmd_word), .cmd_arg(cmd_arg),
        .exec_req(exec_req), .exec_cmd(exec_cmd), .exec_arg(exec_arg),
        .exec_ack(exec_ack), .exec_err(exec_err), .busy(busy), .done(done),
        .err_code(err_code), .cmd_abort(cmd_abort), .pend_ovf(pend_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record whether command 7 ever reached the executor
    always @(posedge clk) begin
        if (exec_req && exec_cmd == 8'd7) saw7 = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CMD_W-1:0] pick_new(input logic [CMD_W-1:0] avoid);
        logic [CMD_W-1:0] v;
        v = CMD_W'($urandom_range(1, 24));
        while (v == avoid) v = CMD_W'($urandom_range(1, 24));
        return v;
    endfunction

    logic [CMD_W-1:0] cur, c1, c2;
    logic [ARG_W-1:0] a1, a2;
    logic [1:0]       exp_err;
    int               mode, d, hi;
    logic             use2;

    initial begin
        rst_n    = 1'b0;
        cmd_word = '0;
        cmd_arg  = '0;
        exec_ack = 1'b0;
        exec_err = 1'b0;
        step();
        step();
        // Reset values
        chk("rst_req",   32'(exec_req),  0);
        chk("rst_cmd",   32'(exec_cmd),  0);
        chk("rst_arg",   32'(exec_arg),  0);
        chk("rst_busy",  32'(busy),      0);
        chk("rst_done",  32'(done),      0);
        chk("rst_err",   32'(err_code),  0);
        chk("rst_abort", 32'(cmd_abort), 0);
        chk("rst_ovf",   32'(pend_ovf),  0);
        rst_n = 1'b1;
        step();

        // Normal command 3 / 0x1234, ack 5 cycles after request
        cmd_word = 8'd3; cmd_arg = 16'h1234;
        step();
        chk("t1_req",  32'(exec_req), 1);
        chk("t1_cmd",  32'(exec_cmd), 3);
        chk("t1_arg",  32'(exec_arg), 32'h1234);
        chk("t1_busy", 32'(busy),     1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_hold", 32'(exec_req), 1);
        end
        exec_ack = 1'b1; exec_err = 1'b0;
        step();
        exec_ack = 1'b0;
        chk("t1_done", 32'(done),     1);
        chk("t1_req0", 32'(exec_req), 0);
        chk("t1_err",  32'(err_code), 0);
        step();
        chk("t1_done0", 32'(done), 0);
        chk("t1_idle",  32'(busy), 0);

        // Illegal command
        cmd_word = 8'h20;
        step();
        chk("t2_req",  32'(exec_req), 0);
        chk("t2_done", 32'(done),     1);
        chk("t2_err",  32'(err_code), 1);
        step();
        chk("t2_done0", 32'(done), 0);

        // Host zero write clears status
        cmd_word = 8'd0;
        step();
        chk("t3_err", 32'(err_code), 0);

        // Timeout
        cmd_word = 8'd5;
        step();
        hi = 0;
        while (exec_req && hi < 40) begin
            hi++;
            step();
        end
        chk("t4_len",   32'(hi),        TIMEOUT);
        chk("t4_abort", 32'(cmd_abort), 1);
        chk("t4_done",  32'(done),      1);
        chk("t4_err",   32'(err_code),  3);
        step();
        chk("t4_abort0", 32'(cmd_abort), 0);

        // Pending overwrite: 2 issued, 7 and 9 arrive before ack
        cmd_word = 8'd2; cmd_arg = 16'h0002;
        step();
        chk("t5_cmd2", 32'(exec_cmd), 2);
        cmd_word = 8'd7; cmd_arg = 16'h0007;
        step();
        cmd_word = 8'd9; cmd_arg = 16'h0009;
        step();
        chk("t5_ovf", 32'(pend_ovf), 1);
        exec_ack = 1'b1;
        step();
        exec_ack = 1'b0;
        chk("t5_done", 32'(done), 1);
        step();
        step();
        chk("t5_req9", 32'(exec_req), 1);
        chk("t5_cmd9", 32'(exec_cmd), 9);
        chk("t5_arg9", 32'(exec_arg), 9);
        exec_ack = 1'b1;
        step();
        exec_ack = 1'b0;
        step();
        chk("t5_idle", 32'(busy), 0);
        chk("t5_no7",  32'(saw7), 0);
        cmd_word = 8'd0;
        step();
        chk("t5_ovf_clr", 32'(pend_ovf), 0);

        // Zero and ack in the same cycle: ack wins
        cmd_word = 8'd4;
        step();
        step();
        cmd_word = 8'd0; exec_ack = 1'b1;
        step();
        exec_ack = 1'b0;
        chk("t6_done",  32'(done),      1);
        chk("t6_abort", 32'(cmd_abort), 0);
        chk("t6_err",   32'(err_code),  0);
        step();
        step();

        // Asynchronous reset mid WAIT_ACK
        cmd_word = 8'd1;
        step();
        chk("t7_req_pre", 32'(exec_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_req",   32'(exec_req),  0);
        chk("t7_busy",  32'(busy),      0);
        chk("t7_err",   32'(err_code),  0);
        chk("t7_abort", 32'(cmd_abort), 0);
        cmd_word = 8'd0;
        step();
        rst_n = 1'b1;
        step();

        // After reset: cmd 6 accepted, executor reports error
        cmd_word = 8'd6; cmd_arg = 16'hBEEF;
        step();
        chk("t8_req", 32'(exec_req), 1);
        chk("t8_cmd", 32'(exec_cmd), 6);
        chk("t8_arg", 32'(exec_arg), 32'hBEEF);
        exec_ack = 1'b1; exec_err = 1'b1;
        step();
        exec_ack = 1'b0; exec_err = 1'b0;
        chk("t8_done", 32'(done),     1);
        chk("t8_err",  32'(err_code), 2);
        step();
        cur = 8'd6;
        exp_err = 2'd2;

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            c1 = pick_new(cur);
            a1 = ARG_W'($urandom);
            mode = $urandom_range(0, 3);
            d = $urandom_range(2, TIMEOUT - 1);
            use2 = ($urandom_range(0, 2) == 0);
            c2 = pick_new(c1);
            a2 = ARG_W'($urandom);
            cmd_word = c1; cmd_arg = a1; cur = c1;
            step();
            if (c1 > MAX_CMD) begin
                chk("r_ill_req",  32'(exec_req), 0);
                chk("r_ill_done", 32'(done),     1);
                chk("r_ill_err",  32'(err_code), 1);
                exp_err = 2'd1;
                step();
                chk("r_ill_done0", 32'(done), 0);
                continue;
            end
            chk("r_req", 32'(exec_req), 1);
            chk("r_cmd", 32'(exec_cmd), 32'(c1));
            chk("r_arg", 32'(exec_arg), 32'(a1));
            exp_err = 2'd0;
            hi = 1;
            if (use2) begin
                cmd_word = c2; cmd_arg = a2; cur = c2;
                step();
                chk("r_hold2", 32'(exec_req), 1);
                hi++;
            end
            if (mode == 2) begin
                while (exec_req && hi < 40) begin
                    step();
                    if (exec_req) hi++;
                end
                chk("r_to_len",   32'(hi),        TIMEOUT);
                chk("r_to_abort", 32'(cmd_abort), 1);
                chk("r_to_done",  32'(done),      1);
                chk("r_to_err",   32'(err_code),  3);
                exp_err = 2'd3;
            end else begin
                while (hi < d) begin
                    step();
                    chk("r_hold", 32'(exec_req), 1);
                    hi++;
                end
                if (mode == 3) begin
                    cmd_word = 8'd0; cur = 8'd0;
                    step();
                    chk("r_ab_req",   32'(exec_req),  0);
                    chk("r_ab_abort", 32'(cmd_abort), 1);
                    chk("r_ab_done",  32'(done),      0);
                    chk("r_ab_err",   32'(err_code),  32'(exp_err));
                    step();
                    chk("r_ab_idle",  32'(busy), 0);
                    chk("r_ab_done2", 32'(done), 0);
                    continue;
                end
                exec_ack = 1'b1; exec_err = mode[0];
                step();
                exec_ack = 1'b0; exec_err = 1'($urandom);
                exp_err = (mode == 1) ? 2'd2 : 2'd0;
                chk("r_ack_done",  32'(done),      1);
                chk("r_ack_req",   32'(exec_req),  0);
                chk("r_ack_abort", 32'(cmd_abort), 0);
                chk("r_ack_err",   32'(err_code),  32'(exp_err));
            end
            step();
            chk("r_fin_done0", 32'(done), 0);
            if (use2) begin
                step();
                if (c2 > MAX_CMD) begin
                    chk("r_p_ill_done", 32'(done),     1);
                    chk("r_p_ill_err",  32'(err_code), 1);
                    chk("r_p_ill_req",  32'(exec_req), 0);
                end else begin
                    chk("r_p_req", 32'(exec_req), 1);
                    chk("r_p_cmd", 32'(exec_cmd), 32'(c2));
                    chk("r_p_arg", 32'(exec_arg), 32'(a2));
                    exec_ack = 1'b1; exec_err = 1'b0;
                    step();
                    exec_ack = 1'b0;
                    chk("r_p_done", 32'(done),     1);
                    chk("r_p_err",  32'(err_code), 0);
                end
                step();
            end
            chk("r_end_idle", 32'(busy), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
